uart_rx: RTL and testbench
==========================

// Module: uart_rx
// PURPOSE
//   Serial receiver that consumes the 8N1 line produced by the transmit stage.
//   Runs on the same 16x-oversampled clock: one bit lasts OVERSAMPLE clocks.
//   Synchronises the async line and detects the start bit.
//   Majority-votes three mid-bit samples per bit, shifts data in LSB first and
//   checks the stop bit. Hands each byte to the consumer with a 1-cycle strobe.
// PARAMETERS
//   OVERSAMPLE  16  clocks per bit; even, >= 8
//   DATA_BITS   8   data bits per frame, LSB first
// PORTS
//   clk          in   1          system clock, = 16x baud; all logic on posedge
//   rst_n        in   1          async active-low reset
//   bit_in       in   1          serial line, idle high, asynchronous to clk
//   data_out     out  DATA_BITS  last good byte; held until the next good frame
//   data_valid   out  1          1-cycle pulse: data_out was updated this cycle
//   framing_err  out  1          1-cycle pulse: stop bit sampled low
//   busy         out  1          high whenever the FSM is not in IDLE
// BEHAVIOUR
// - Reset, async, while rst_n=0:
//     FSM=IDLE, tick=0, bit_idx=0, shift=0.
//     Both synchroniser FFs=1.
//     data_out=0, data_valid=0, framing_err=0, busy=0.
//   Reset mid-frame aborts the frame and produces no strobe.
// - Synchroniser: 2 FFs, bit_in -> s1 -> rx_s. All decisions use rx_s only.
// - tick counts 0..OVERSAMPLE-1 within each bit.
//   On tick=OVERSAMPLE-1 it wraps to 0 and the bit phase advances.
// - Mid-bit decision, M = OVERSAMPLE/2:
//   - rx_s is registered at tick=M-1 and at tick=M.
//   - At tick=M+1: bit = majority(sample M-1, sample M, current rx_s).
// - FSM states:
//   IDLE
//     rx_s=0 -> START, tick=0.
//   START
//     decision=1 -> IDLE (glitch rejected, no strobe).
//     decision=0 -> continue; at wrap -> DATA, bit_idx=0.
//   DATA
//     At decision: shift <= {bit, shift[DATA_BITS-1:1]}.
//     At wrap: bit_idx+1; after bit_idx=DATA_BITS-1 -> STOP.
//   STOP (acts at decision tick, does not wait for wrap):
//     decision=1 -> data_out<=shift, data_valid=1 for one cycle, -> IDLE.
//       Leaving early lets a start bit arriving at the nominal bit boundary
//       be caught.
//     decision=0 -> framing_err=1 for one cycle, data_out unchanged, -> BREAK.
//   BREAK
//     Stay until rx_s=1, then -> IDLE. A held-low line never retriggers.
// - data_valid and framing_err are mutually exclusive and never both high.
// - busy=1 in START, DATA, STOP and BREAK.
//   busy drops in the same cycle data_valid or framing_err rises (BREAK: when rx_s=1).
// - Latency, defaults: edge E0 is the first posedge sampling bit_in=0.
//   - FSM enters START after E0+2.
//   - data_valid is high in the cycle after edge E0+156.
//   - General form: 2 + (DATA_BITS+1)*OVERSAMPLE + M + 2.
// - Tolerance: mid-bit sampling accepts a cumulative baud error up to
//   ±(M-2) clocks at the stop bit.
// - Frames may be back-to-back with zero idle bits; none may be lost.
// TESTING
//   T1 Frame 0xA5 at 16 clk/bit -> data_out=0xA5.
//      data_valid high exactly 1 cycle, 156 cycles after E0; framing_err=0.
//   T2 bit_in low for 4 clocks, then high -> no strobe.
//      busy returns to 0 within 11 cycles; FSM in IDLE.
//   T3 Frame 0x3C with stop bit driven 0, line held low 40 clocks, then high:
//      -> framing_err 1 pulse; data_out keeps previous 0xA5; busy until line high.
//      -> Following frame 0x01 received correctly.
//   T4 Back-to-back 0x00, 0xFF, 0x55 with no idle gap -> three data_valid
//      pulses 160 cycles apart, with correct values.
//   T5 Frame 0x0F with a 1-clock inverted glitch at tick 8 of every data bit
//      -> data_out=0x0F (majority vote).
//   T6 rst_n pulsed low during data bit 4 of 0xC3 -> all outputs 0 immediately.
//      Next frame 0x7E -> data_out=0x7E.
//      Also loop back from the transmit stage: bytes 0x00..0xFF all received in order.

Source files
------------

// File: rtl/uart_rx.sv
// 8N1 serial receiver running on a clock OVERSAMPLE times the baud rate.
// Synchronises the line, majority-votes three mid-bit samples and strobes each good byte.
module uart_rx #(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 bit_in,
  output logic [DATA_BITS-1:0] data_out,
  output logic                 data_valid,
  output logic                 framing_err,
  output logic                 busy
);

  localparam int M  = OVERSAMPLE / 2;
  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);

  localparam logic [TW-1:0] TICK_SAMPLE_A = TW'(M - 1);
  localparam logic [TW-1:0] TICK_SAMPLE_B = TW'(M);
  localparam logic [TW-1:0] TICK_DECIDE   = TW'(M + 1);
  localparam logic [TW-1:0] TICK_LAST     = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] IDX_LAST      = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_e;

  state_e                 state_q, state_d;
  logic                   s1_q, rx_s_q;
  logic [TW-1:0]          tick_q, tick_d;
  logic [BW-1:0]          bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   samp_a_q, samp_a_d;
  logic                   samp_b_q, samp_b_d;
  logic [DATA_BITS-1:0]   data_out_q, data_out_d;
  logic                   data_valid_q, data_valid_d;
  logic                   framing_err_q, framing_err_d;

  logic                   wrap, decide, vote;
  logic [TW-1:0]          tick_inc;

  // The synchroniser resets to the idle-high line level so reset release
  // can never look like a start bit.
  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the values from before this edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q          <= 1'b1;
      rx_s_q        <= 1'b1;
      state_q       <= S_IDLE;
      tick_q        <= '0;
      bit_idx_q     <= '0;
      shift_q       <= '0;
      samp_a_q      <= 1'b0;
      samp_b_q      <= 1'b0;
      data_out_q    <= '0;
      data_valid_q  <= 1'b0;
      framing_err_q <= 1'b0;
    end else begin
      s1_q          <= bit_in;
      rx_s_q        <= s1_q;
      state_q       <= state_d;
      tick_q        <= tick_d;
      bit_idx_q     <= bit_idx_d;
      shift_q       <= shift_d;
      samp_a_q      <= samp_a_d;
      samp_b_q      <= samp_b_d;
      data_out_q    <= data_out_d;
      data_valid_q  <= data_valid_d;
      framing_err_q <= framing_err_d;
    end
  end

  assign wrap     = (tick_q == TICK_LAST);
  assign decide   = (tick_q == TICK_DECIDE);
  assign tick_inc = wrap ? '0 : tick_q + TW'(1);
  assign vote     = (samp_a_q & samp_b_q) | (samp_a_q & rx_s_q) | (samp_b_q & rx_s_q);

  // NOTE: every signal written here is defaulted first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d       = state_q;
    tick_d        = tick_q;
    bit_idx_d     = bit_idx_q;
    shift_d       = shift_q;
    samp_a_d      = samp_a_q;
    samp_b_d      = samp_b_q;
    data_out_d    = data_out_q;
    data_valid_d  = 1'b0;
    framing_err_d = 1'b0;

    if (tick_q == TICK_SAMPLE_A) samp_a_d = rx_s_q;
    if (tick_q == TICK_SAMPLE_B) samp_b_d = rx_s_q;

    unique case (state_q)
      S_IDLE: begin
        tick_d    = '0;
        bit_idx_d = '0;
        if (!rx_s_q) state_d = S_START;
      end
      S_START: begin
        tick_d = tick_inc;
        if (decide && vote) begin
          state_d = S_IDLE;
          tick_d  = '0;
        end else if (wrap) begin
          state_d   = S_DATA;
          bit_idx_d = '0;
        end
      end
      S_DATA: begin
        tick_d = tick_inc;
        if (decide) shift_d = {vote, shift_q[DATA_BITS-1:1]};
        if (wrap) begin
          if (bit_idx_q == IDX_LAST) state_d = S_STOP;
          else bit_idx_d = bit_idx_q + BW'(1);
        end
      end
      S_STOP: begin
        // Leave at the decision point so a start bit right at the nominal
        // bit boundary is still seen from IDLE.
        tick_d = tick_inc;
        if (decide) begin
          tick_d = '0;
          if (vote) begin
            data_out_d   = shift_q;
            data_valid_d = 1'b1;
            state_d      = S_IDLE;
          end else begin
            framing_err_d = 1'b1;
            state_d       = S_BREAK;
          end
        end
      end
      S_BREAK: begin
        tick_d = '0;
        if (rx_s_q) state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        tick_d  = '0;
      end
    endcase
  end

  assign data_out    = data_out_q;
  assign data_valid  = data_valid_q;
  assign framing_err = framing_err_q;
  assign busy        = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: directed frames plus random and loopback
// traffic, scored against a queue of bytes the serial driver actually sent.
module tb_uart_rx;

  localparam int OS = 16;
  localparam int DB = 8;
  localparam int LAT = 2 + (DB + 1) * OS + OS / 2 + 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          bit_in;
  logic [DB-1:0] data_out;
  logic          data_valid;
  logic          framing_err;
  logic          busy;

  uart_rx #(.OVERSAMPLE(OS), .DATA_BITS(DB)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .bit_in     (bit_in),
    .data_out   (data_out),
    .data_valid (data_valid),
    .framing_err(framing_err),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_fail   = 0;

  int            dv_cyc[$];
  logic [DB-1:0] dv_val[$];
  int            fe_cyc[$];
  logic [DB-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Strobe monitor, sampled on the falling edge away from the active edge.
  always @(negedge clk) begin
    if (rst_n && (data_valid || framing_err)) begin
      check("strobe_excl", {31'b0, data_valid & framing_err}, 32'd0);
      if (data_valid) begin
        dv_cyc.push_back(cyc);
        dv_val.push_back(data_out);
      end
      if (framing_err) fe_cyc.push_back(cyc);
    end
  end

  task automatic drive(input logic v, input int n);
    bit_in = v;
    repeat (n) @(negedge clk);
  endtask

  // One 8N1 frame. skew>0 stretches the first |skew| bits by a clock,
  // skew<0 shortens them; glitch inverts one clock at position 8 of each data bit.
  task automatic send_frame(input logic [DB-1:0] b, input logic stop_v, input int skew,
                            input bit glitch, output int e0);
    int nadj;
    int dlt;
    int w;
    logic v;
    nadj = (skew < 0) ? -skew : skew;
    dlt  = (skew < 0) ? -1 : 1;
    e0   = cyc + 1;
    for (int k = 0; k < DB + 2; k++) begin
      v = (k == 0) ? 1'b0 : (k == DB + 1) ? stop_v : b[k-1];
      w = OS + ((k < nadj) ? dlt : 0);
      if (glitch && k >= 1 && k <= DB) begin
        drive(v, 8);
        drive(~v, 1);
        drive(v, w - 9);
      end else begin
        drive(v, w);
      end
    end
  endtask

  task automatic send_good(input logic [DB-1:0] b, input int skew, input bit glitch, output int e0);
    exp_q.push_back(b);
    send_frame(b, 1'b1, skew, glitch, e0);
  endtask

  task automatic drain_check(input string tag);
    check({tag, "_count"}, dv_val.size(), exp_q.size());
    while (dv_val.size() > 0 && exp_q.size() > 0)
      check({tag, "_data"}, {24'b0, dv_val.pop_front()}, {24'b0, exp_q.pop_front()});
    dv_val.delete();
    dv_cyc.delete();
    fe_cyc.delete();
    exp_q.delete();
  endtask

  initial begin
    int e0;
    int e0_first;
    logic [DB-1:0] rb;
    logic [DB-1:0] c3;

    rst_n  = 1'b0;
    bit_in = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_data_out", {24'b0, data_out}, 32'd0);
    check("rst_valid", {31'b0, data_valid}, 32'd0);
    check("rst_ferr", {31'b0, framing_err}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    rst_n = 1'b1;
    drive(1'b1, 20);

    // T1: single frame, exact latency and single-cycle strobe
    send_good(8'hA5, 0, 1'b0, e0);
    drive(1'b1, 20);
    check("t1_latency", (dv_cyc.size() > 0) ? dv_cyc[0] : -1, e0 + LAT);
    check("t1_ferr_count", fe_cyc.size(), 0);
    check("t1_data_out", {24'b0, data_out}, 32'hA5);
    drain_check("t1");

    // T2: short low glitch is rejected
    e0 = cyc + 1;
    drive(1'b0, 4);
    check("t2_busy_rise", {31'b0, busy}, 32'd1);
    drive(1'b1, 9);
    check("t2_busy_fall", {31'b0, busy}, 32'd0);
    drive(1'b1, 20);
    check("t2_ferr_count", fe_cyc.size(), 0);
    drain_check("t2");

    // T3: stop bit low, line held in break, then recovery
    send_frame(8'h3C, 1'b0, 0, 1'b0, e0);
    drive(1'b0, 40);
    check("t3_busy_break", {31'b0, busy}, 32'd1);
    check("t3_ferr_count", fe_cyc.size(), 1);
    check("t3_ferr_time", (fe_cyc.size() > 0) ? fe_cyc[0] : -1, e0 + LAT);
    check("t3_data_held", {24'b0, data_out}, 32'hA5);
    drive(1'b1, 4);
    check("t3_busy_clear", {31'b0, busy}, 32'd0);
    drain_check("t3");
    drive(1'b1, 16);
    send_good(8'h01, 0, 1'b0, e0);
    drive(1'b1, 20);
    check("t3_next_data", {24'b0, data_out}, 32'h01);
    drain_check("t3b");

    // T4: back-to-back frames, no idle between them
    send_good(8'h00, 0, 1'b0, e0_first);
    send_good(8'hFF, 0, 1'b0, e0);
    send_good(8'h55, 0, 1'b0, e0);
    drive(1'b1, 20);
    check("t4_first_time", (dv_cyc.size() > 0) ? dv_cyc[0] : -1, e0_first + LAT);
    check("t4_gap1", (dv_cyc.size() > 1) ? dv_cyc[1] - dv_cyc[0] : -1, (DB + 2) * OS);
    check("t4_gap2", (dv_cyc.size() > 2) ? dv_cyc[2] - dv_cyc[1] : -1, (DB + 2) * OS);
    drain_check("t4");

    // T5: glitch in every data bit is outvoted
    send_good(8'h0F, 0, 1'b1, e0);
    drive(1'b1, 20);
    check("t5_data_out", {24'b0, data_out}, 32'h0F);
    drain_check("t5");

    // Baud error at the edge of the tolerated range, both directions
    send_good(8'h96, 5, 1'b0, e0);
    drive(1'b1, 20);
    send_good(8'h69, -5, 1'b0, e0);
    drive(1'b1, 20);
    drain_check("skew");

    // T6: reset in data bit 4 aborts the frame
    c3 = 8'hC3;
    drive(1'b0, OS);
    for (int k = 0; k < 4; k++) drive(c3[k], OS);
    drive(c3[4], 8);
    check("t6_busy_pre", {31'b0, busy}, 32'd1);
    rst_n  = 1'b0;
    bit_in = 1'b1;
    #1;
    check("t6_rst_data", {24'b0, data_out}, 32'd0);
    check("t6_rst_valid", {31'b0, data_valid}, 32'd0);
    check("t6_rst_ferr", {31'b0, framing_err}, 32'd0);
    check("t6_rst_busy", {31'b0, busy}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 40);
    check("t6_abort_ferr", fe_cyc.size(), 0);
    drain_check("t6_abort");
    send_good(8'h7E, 0, 1'b0, e0);
    drive(1'b1, 20);
    check("t6_data_out", {24'b0, data_out}, 32'h7E);
    drain_check("t6");

    // Random bytes with random idle gaps (including none)
    for (int i = 0; i < 40; i++) begin
      rb = DB'($urandom);
      send_good(rb, 0, 1'b0, e0);
      drive(1'b1, OS * $urandom_range(0, 2));
    end
    drive(1'b1, 20);
    check("rand_ferr_count", fe_cyc.size(), 0);
    drain_check("rand");

    // Loopback traffic: every byte value in order, back-to-back
    for (int i = 0; i < 256; i++) send_good(DB'(i), 0, 1'b0, e0);
    drive(1'b1, 20);
    check("loop_ferr_count", fe_cyc.size(), 0);
    check("loop_last", {24'b0, data_out}, 32'hFF);
    drain_check("loop");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
